bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Parametrised multi-digit BCD countdown timer: generalises the single-digit 9→0 one-second countdown to DIGITS BCD digits, a programmable preset, start/pause/load control, a configurable tick period and an expiry flag. Feeds the 7-segment display scan logic (bcd_out) and board-level control (done/expired) on the 50 MHz BASYS2 clock.

## Interface
- TICK_DIV, 50_000_000: clk cycles per countdown tick; legal range ≥ 2.
- DIGITS, 2: number of BCD digits; legal range 1–8.
- clk  in  1  system clock; all registers update on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- load  in  1  capture load_val into preset and count.
- load_val  in  4*DIGITS  BCD preset; digit i at bits [4i+3:4i].
- start  in  1  begin or resume counting.
- pause  in  1  freeze counting.
- bcd_out  out  4*DIGITS  current count, BCD.
- tick  out  1  one-cycle pulse on each count update.
- done  out  1  one-cycle pulse when count reaches zero.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: state IDLE; preset and count all digits 9; prescaler 0; tick, done, running, expired 0.
- Control priority per cycle: reset > load > pause > start.
- load (any state): preset ← load_val, count ← load_val, prescaler ← 0, state → IDLE. Digits > 9 clamp to 9 in both preset and count.
- start in IDLE or PAUSE: count ≠ 0 → RUN; count = 0 → EXPIRED with done pulse. start in RUN or EXPIRED: ignored.
- pause in RUN → PAUSE, prescaler and count held. pause in other states: ignored. start and pause together: pause wins.
- RUN: prescaler increments each cycle; at prescaler = TICK_DIV−1 it returns to 0, tick pulses, and count decrements once.
- BCD decrement: least significant digit −1; a digit at 0 becomes 9 and borrows from the next digit; no binary values A–F ever appear on bcd_out.
- Reaching zero: the decrement that makes count = 0 also pulses done in the same cycle. Behaviour after that is set by Configuration.
- EXPIRED: count held at 0; leaves only via load or reset.
- Prescaler width = ceil(log2(TICK_DIV)); must not wrap before TICK_DIV−1.

## Timing
- All outputs registered; reset, load or start takes effect on the next rising edge.
- start accepted at edge N: running high after N; first tick/count update at edge N+TICK_DIV; subsequent updates every TICK_DIV cycles.
- PAUSE then start: remaining partial period resumes from the held prescaler value, with no lost or extra cycles.
- done and tick are exactly one cycle wide and coincide with the edge that loads the new count.
- Reset mid-period: prescaler cleared; no tick or done is generated from the partial period.

## Configuration
- TIMER_AUTORELOAD_EN defined: on the tick where count = 0 in RUN, count ← preset (tick pulses, done does not); the state stays RUN. EXPIRED is then reachable only via start with count = 0. With preset = 0, done pulses on every tick.
- Not defined: the done-producing decrement moves state to EXPIRED; expired rises on the same edge; running falls.

## Test plan
- TICK_DIV=4, DIGITS=2: reset, then start → bcd_out 99, first tick 4 cycles after start, then 98; expired 0.
- Load 0x10, start → 10, 09 (borrow), …, 01, 00 with done at the 00 edge; without AUTORELOAD, expired=1 and count is held at 00 for 20 further cycles.
- Load 0x3F → bcd_out reads 0x39; start, pause after 2 cycles for 10 cycles, start → the next tick arrives 2 RUN cycles after resume.
- Start and pause asserted together in IDLE → stays IDLE; load and start together → load wins, state IDLE.
- With TIMER_AUTORELOAD_EN, load 0x02 → 02, 01, 00 (done), 02 on the next tick, running stays 1.
- Reset asserted mid-period in RUN → next cycle bcd_out 0x99, running 0, no tick for ≥ 8 cycles.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// bcd_countdown_timer: DIGITS-digit BCD countdown with preset, start/pause/load,
// TICK_DIV-cycle tick prescaler and expiry flag. Option: TIMER_AUTORELOAD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_countdown_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIGITS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                tick,
  output logic                done,
  output logic                running,
  output logic                expired
);

  localparam int c_w  = 4 * DIGITS;
  localparam int c_pw = $clog2(TICK_DIV);
  localparam logic [c_pw-1:0] c_pre_last = c_pw'(TICK_DIV - 1);
  localparam logic [c_w-1:0]  c_all_nine = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [c_w-1:0]    count_q, count_d;
  logic [c_w-1:0]    preset_q, preset_d;
  logic [c_pw-1:0]   pre_q, pre_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              running_q, expired_q;
  logic [c_w-1:0]    w_load_clamped;
  logic [c_w-1:0]    w_count_dec;

  // Out-of-range BCD digits (A-F) saturate to 9 so bcd_out never shows them.
  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin
    logic borrow;
    borrow      = 1'b1;
    w_count_dec = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          w_count_dec[4*i +: 4] = 4'd9;
        end else begin
          w_count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    pre_d    = pre_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      preset_d = w_load_clamped;
      count_d  = w_load_clamped;
      pre_d    = '0;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (!pause && start) begin
            if (count_q == '0) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (pre_q == c_pre_last) begin
            pre_d  = '0;
            tick_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            if (count_q == '0) begin
              count_d = preset_q;
              done_d  = (preset_q == '0);
            end else begin
              count_d = w_count_dec;
              done_d  = (w_count_dec == '0);
            end
`else
            count_d = w_count_dec;
            if (w_count_dec == '0) begin
              done_d  = 1'b1;
              state_d = S_EXPIRED;
            end
`endif
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= c_all_nine;
      preset_q  <= c_all_nine;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      preset_q  <= preset_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
      expired_q <= (state_d == S_EXPIRED);
    end
  end

  assign bcd_out = count_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// tb_bcd_countdown_timer: directed self-checking bench, TICK_DIV=4, DIGITS=2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [7:0] bcd_out;
  logic       tick;
  logic       done;
  logic       running;
  logic       expired;

  int checks   = 0;
  int failures = 0;

  bcd_countdown_timer #(.TICK_DIV(4), .DIGITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .bcd_out  (bcd_out),
    .tick     (tick),
    .done     (done),
    .running  (running),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (bcd_out !== 8'h99) begin failures++; $display("FAIL reset_bcd got=%h exp=99", bcd_out); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", expired); end
  endtask

  task automatic test_first_tick();
    do_start();
    checks++; if (running !== 1'b1 || bcd_out !== 8'h99) begin failures++; $display("FAIL start_run running=%b bcd=%h exp=1/99", running, bcd_out); end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL early_tick cycle=%0d got=%b exp=0", k, tick); end
    end
    step();
    checks++; if (tick !== 1'b1 || bcd_out !== 8'h98) begin failures++; $display("FAIL first_tick tick=%b bcd=%h exp=1/98", tick, bcd_out); end
    checks++; if (expired !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL first_tick_flags expired=%b done=%b exp=0/0", expired, done); end
    step();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL tick_width got=%b exp=0", tick); end
  endtask

  task automatic test_borrow_expire();
    logic [7:0] exp_bcd;
    do_load(8'h10);
    checks++; if (bcd_out !== 8'h10 || running !== 1'b0) begin failures++; $display("FAIL load10 bcd=%h running=%b exp=10/0", bcd_out, running); end
    do_start();
    for (int e = 9; e >= 0; e--) begin
      for (int k = 0; k < 3; k++) begin
        step();
        checks++; if (tick !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_period e=%0d tick=%b done=%b exp=0/0", e, tick, done); end
      end
      step();
      exp_bcd = 8'(((e / 10) * 16) + (e % 10));
      checks++; if (tick !== 1'b1 || bcd_out !== exp_bcd) begin failures++; $display("FAIL countdown tick=%b bcd=%h exp=1/%h", tick, bcd_out, exp_bcd); end
      checks++; if (done !== (e == 0)) begin failures++; $display("FAIL done_pulse e=%0d got=%b exp=%b", e, done, (e == 0)); end
    end
`ifndef TIMER_AUTORELOAD_EN
    checks++; if (expired !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL expire_flags expired=%b running=%b exp=1/0", expired, running); end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (bcd_out !== 8'h00 || expired !== 1'b1 || tick !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL expired_hold k=%0d bcd=%h expired=%b tick=%b done=%b exp=00/1/0/0", k, bcd_out, expired, tick, done);
      end
    end
`endif
  endtask

  task automatic test_clamp_pause();
    do_load(8'h3F);
    checks++; if (bcd_out !== 8'h39) begin failures++; $display("FAIL clamp got=%h exp=39", bcd_out); end
    do_start();
    step(); step();
    pause = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_enter running=%b exp=0", running); end
    for (int k = 1; k < 10; k++) begin
      step();
      checks++; if (tick !== 1'b0 || bcd_out !== 8'h39) begin failures++; $display("FAIL paused k=%0d tick=%b bcd=%h exp=0/39", k, tick, bcd_out); end
    end
    pause = 1'b0;
    do_start();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume running=%b exp=1", running); end
    step();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL resume_early tick=%b exp=0", tick); end
    step();
    checks++; if (tick !== 1'b1 || bcd_out !== 8'h38) begin failures++; $display("FAIL resume_tick tick=%b bcd=%h exp=1/38", tick, bcd_out); end
  endtask

  task automatic test_conflicts();
    do_load(8'h05);
    start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0; pause = 1'b0;
    checks++; if (running !== 1'b0 || expired !== 1'b0) begin failures++; $display("FAIL start_pause running=%b expired=%b exp=0/0", running, expired); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (tick !== 1'b0 || bcd_out !== 8'h05) begin failures++; $display("FAIL idle_hold tick=%b bcd=%h exp=0/05", tick, bcd_out); end
    end
    start = 1'b1; load = 1'b1; load_val = 8'h07;
    step();
    start = 1'b0; load = 1'b0;
    checks++; if (running !== 1'b0 || bcd_out !== 8'h07) begin failures++; $display("FAIL load_start_idle running=%b bcd=%h exp=0/07", running, bcd_out); end
    do_start();
    start = 1'b1; load = 1'b1; load_val = 8'h42;
    step();
    start = 1'b0; load = 1'b0;
    checks++; if (running !== 1'b0 || bcd_out !== 8'h42) begin failures++; $display("FAIL load_start_run running=%b bcd=%h exp=0/42", running, bcd_out); end
  endtask

  task automatic test_start_zero();
    do_load(8'h00);
    do_start();
    checks++; if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL start_zero done=%b expired=%b running=%b exp=1/1/0", done, expired, running);
    end
    do_start();
    checks++; if (done !== 1'b0 || expired !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL start_in_expired done=%b expired=%b running=%b exp=0/1/0", done, expired, running);
    end
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    do_load(8'h02);
    do_start();
    step(); step(); step(); step();
    checks++; if (bcd_out !== 8'h01 || tick !== 1'b1) begin failures++; $display("FAIL ar_01 bcd=%h tick=%b exp=01/1", bcd_out, tick); end
    step(); step(); step(); step();
    checks++; if (bcd_out !== 8'h00 || done !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL ar_00 bcd=%h done=%b running=%b exp=00/1/1", bcd_out, done, running); end
    step(); step(); step(); step();
    checks++; if (bcd_out !== 8'h02 || tick !== 1'b1 || done !== 1'b0 || running !== 1'b1) begin
      failures++; $display("FAIL ar_reload bcd=%h tick=%b done=%b running=%b exp=02/1/0/1", bcd_out, tick, done, running);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_load(8'h50);
    do_start();
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bcd_out !== 8'h99 || running !== 1'b0 || expired !== 1'b0) begin
      failures++; $display("FAIL reset_mid bcd=%h running=%b expired=%b exp=99/0/0", bcd_out, running, expired);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (tick !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL reset_no_tick k=%0d tick=%b running=%b exp=0/0", k, tick, running); end
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
    test_reset();
    test_first_tick();
    test_borrow_expire();
    test_clamp_pause();
    test_conflicts();
    test_start_zero();
`ifdef TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
